// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin share of one line-granular memory port between I-cache and D-cache, with a sticky watchdog
//   ports: clk, rst (sync, active-high); i_read/i_addr -> i_rdata/i_resp;
//          d_read/d_write/d_addr/d_wdata -> d_rdata/d_resp;
//          m_read/m_write/m_addr/m_wdata <- m_rdata/m_resp; err = sticky watchdog flag
module cache_arbiter #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp,
  output logic              err
);
  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(LINE_W / 8 - 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t state;
  logic last_d;
  logic [WD_W-1:0] wdog;
  logic d_req, pick_d;
  assign d_req   = d_read | d_write;
  assign pick_d  = d_req & (~i_read | ~last_d);
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign i_resp  = (state == SERVE_I) & m_resp;
  assign d_resp  = (state == SERVE_D) & m_resp;
  // Command is latched at grant so a requester dropping mid-transaction cannot abort memory
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      wdog    <= '0;
      err     <= 1'b0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (state == IDLE) begin
      if (i_read | d_req) begin
        state   <= pick_d ? SERVE_D : SERVE_I;
        last_d  <= pick_d;
        wdog    <= '0;
        m_read  <= pick_d ? d_read & ~d_write : 1'b1;
        m_write <= pick_d & d_write;
        m_addr  <= (pick_d ? d_addr : i_addr) & MASK;
        m_wdata <= pick_d ? d_wdata : '0;
      end
    end else if (m_resp) begin
      state   <= IDLE;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      wdog <= (wdog == WD_W'(TIMEOUT)) ? wdog : wdog + 1'b1;
      if (wdog == WD_W'(TIMEOUT - 1)) err <= 1'b1;
    end
  end
endmodule
